// File: rtl/digit_serial_adder_pkg.sv
// ---------------------------------------------------------------
// adder_pkg : shared types and sizing helpers for digit_serial_adder
// Revision  : 1.0
// ---------------------------------------------------------------
`default_nettype none

package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int digit_count(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int C_DEF_WIDTH = 16;
   localparam int C_DEF_DIGIT = 4;
   localparam int C_DEF_N     = digit_count(C_DEF_WIDTH, C_DEF_DIGIT);
   localparam int C_DEF_CNT_W = cnt_width(C_DEF_N);

endpackage

`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
// ---------------------------------------------------------------
// digit_serial_adder_if : operand/result valid-ready bundle
// Revision              : 1.0
// ---------------------------------------------------------------
`default_nettype none

interface digit_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid_in;
   logic             in_ready_out;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             sub_in;
   logic             out_valid_out;
   logic             out_ready_in;
   logic [WIDTH-1:0] sum_out;
   logic             c_out;
   logic             v_out;
   logic             p_out;
   logic             g_out;

   // slave = the adder, master = whoever feeds and drains it
   modport slave (
      input  in_valid_in, a_in, b_in, c_in, sub_in, out_ready_in,
      output in_ready_out, out_valid_out, sum_out, c_out, v_out, p_out, g_out
   );

   modport master (
      output in_valid_in, a_in, b_in, c_in, sub_in, out_ready_in,
      input  in_ready_out, out_valid_out, sum_out, c_out, v_out, p_out, g_out
   );
endinterface

`default_nettype wire

// File: rtl/digit_adder_slice.sv
// ---------------------------------------------------------------
// digit_adder_slice : combinational DIGIT-bit ripple adder with P/G
// Revision          : 1.0
// ---------------------------------------------------------------
`default_nettype none

module digit_adder_slice #(
   parameter int DIGIT = 4
) (
   input  wire logic [DIGIT-1:0] a,
   input  wire logic [DIGIT-1:0] b,
   input  wire logic             c,
   output logic      [DIGIT-1:0] sum,
   output logic                  c_out,
   output logic                  c_msb_in,
   output logic                  p_d,
   output logic                  g_d
);
   logic [DIGIT-1:0] w_p;
   logic [DIGIT-1:0] w_g;
   logic [DIGIT:0]   w_c;
   logic [DIGIT:0]   w_gg;

   assign w_c[0]  = c;
   assign w_gg[0] = 1'b0;

   // w_c carries the real carry-in, w_gg the same chain seeded with zero
   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign w_p[i]    = a[i] | b[i];
      assign w_g[i]    = a[i] & b[i];
      assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = w_g[i] | (w_p[i] & w_c[i]);
      assign w_gg[i+1] = w_g[i] | (w_p[i] & w_gg[i]);
   end

   assign c_out    = w_c[DIGIT];
   assign c_msb_in = w_c[DIGIT-1];
   assign p_d      = &w_p;
   assign g_d      = w_gg[DIGIT];

endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------
// digit_serial_adder : LSB-first digit-serial add/sub with word P/G
// Revision           : 1.0
// ---------------------------------------------------------------
`default_nettype none

module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  wire logic          clk_in,
   input  wire logic          rst_n_in,
   digit_serial_adder_if.slave bus
);
   localparam int                 C_N     = digit_count(WIDTH, DIGIT);
   localparam int                 C_CNT_W = cnt_width(C_N);
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_N - 1);

   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
   end

   state_e             r_state;
   state_e             w_next;
   logic               w_in_ready;
   logic               w_out_valid;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_v;
   logic               r_p;
   logic               r_g;
   logic [C_CNT_W-1:0] r_cnt;

   logic [DIGIT-1:0]   w_sum_d;
   logic               w_c_out;
   logic               w_c_msb;
   logic               w_p_d;
   logic               w_g_d;
   logic [WIDTH-1:0]   w_b_eff;
   logic [WIDTH-1:0]   w_sum_next;

   assign w_b_eff    = bus.sub_in ? ~bus.b_in : bus.b_in;
   // New digit enters at the MSB end; after N digits the word is aligned
   assign w_sum_next = WIDTH'({w_sum_d, r_sum} >> DIGIT);

   digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
      .a        (r_a[DIGIT-1:0]),
      .b        (r_b[DIGIT-1:0]),
      .c        (r_carry),
      .sum      (w_sum_d),
      .c_out    (w_c_out),
      .c_msb_in (w_c_msb),
      .p_d      (w_p_d),
      .g_d      (w_g_d)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid_in) w_next = BUSY;
         end
         BUSY: begin
            if (r_cnt == C_LAST) w_next = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready_in) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_v     <= 1'b0;
         r_p     <= 1'b0;
         r_g     <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid_in) begin
                  r_a     <= bus.a_in;
                  r_b     <= w_b_eff;
                  r_carry <= bus.c_in;
                  r_cnt   <= '0;
                  r_p     <= 1'b1;
                  r_g     <= 1'b0;
               end
            end
            BUSY: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_sum   <= w_sum_next;
               r_carry <= w_c_out;
               // only the value written on the final digit is observed
               r_v     <= w_c_msb ^ w_c_out;
               r_p     <= r_p & w_p_d;
               r_g     <= w_g_d | (w_p_d & r_g);
               r_cnt   <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready_out  = w_in_ready;
   assign bus.out_valid_out = w_out_valid;
   assign bus.sum_out       = r_sum;
   assign bus.c_out         = r_carry;
   assign bus.v_out         = r_v;
   assign bus.p_out         = r_p;
   assign bus.g_out         = r_g;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// ---------------------------------------------------------------
// tb_digit_serial_adder : directed bench for DIGIT=4 and DIGIT=16
// Revision              : 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_digit_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   digit_serial_adder_if #(.WIDTH(16)) bus4 ();
   digit_serial_adder_if #(.WIDTH(16)) bus16 ();

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus4)
   );

   digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input logic [15:0] esum,
                         input logic ec, input logic ev, input logic ep, input logic eg);
      int lat;
      check({tag, " in_ready"}, 32'(bus4.in_ready_out), 32'd1);
      bus4.a_in        = a;
      bus4.b_in        = b;
      bus4.c_in        = ci;
      bus4.sub_in      = sb;
      bus4.in_valid_in = 1'b1;
      tick();
      bus4.in_valid_in = 1'b0;
      lat = 0;
      while (!bus4.out_valid_out && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " sum"}, 32'(bus4.sum_out), 32'(esum));
      check({tag, " c"}, 32'(bus4.c_out), 32'(ec));
      check({tag, " v"}, 32'(bus4.v_out), 32'(ev));
      check({tag, " p"}, 32'(bus4.p_out), 32'(ep));
      check({tag, " g"}, 32'(bus4.g_out), 32'(eg));
      bus4.out_ready_in = 1'b1;
      tick();
      bus4.out_ready_in = 1'b0;
   endtask

   initial begin
      int lat;
      bus4.in_valid_in   = 1'b0;
      bus4.a_in          = '0;
      bus4.b_in          = '0;
      bus4.c_in          = 1'b0;
      bus4.sub_in        = 1'b0;
      bus4.out_ready_in  = 1'b0;
      bus16.in_valid_in  = 1'b0;
      bus16.a_in         = '0;
      bus16.b_in         = '0;
      bus16.c_in         = 1'b0;
      bus16.sub_in       = 1'b0;
      bus16.out_ready_in = 1'b0;

      #3;
      check("reset in_ready", 32'(bus4.in_ready_out), 32'd1);
      check("reset out_valid", 32'(bus4.out_valid_out), 32'd0);
      check("reset sum", 32'(bus4.sum_out), 32'd0);
      check("reset cvpg", 32'({bus4.c_out, bus4.v_out, bus4.p_out, bus4.g_out}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_op("t1 add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("t2 wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      run_op("t3 posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("t3 negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      run_op("t4 borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("t4 noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);

      // t5: stall in DONE while new operands are offered
      bus4.a_in        = 16'h00FF;
      bus4.b_in        = 16'h0F0F;
      bus4.c_in        = 1'b1;
      bus4.sub_in      = 1'b0;
      bus4.in_valid_in = 1'b1;
      tick();
      bus4.in_valid_in = 1'b0;
      lat = 0;
      while (!bus4.out_valid_out && lat < 20) begin
         tick();
         lat++;
      end
      check("t5 latency", 32'(lat), 32'd4);
      check("t5 sum", 32'(bus4.sum_out), 32'h100F);
      for (int i = 0; i < 5; i++) begin
         bus4.in_valid_in = (i % 2 == 0);
         bus4.a_in        = 16'hAAAA;
         bus4.b_in        = 16'h5555;
         bus4.c_in        = 1'b0;
         tick();
         check("t5 hold out_valid", 32'(bus4.out_valid_out), 32'd1);
         check("t5 hold in_ready", 32'(bus4.in_ready_out), 32'd0);
         check("t5 hold sum", 32'(bus4.sum_out), 32'h100F);
         check("t5 hold cvpg", 32'({bus4.c_out, bus4.v_out, bus4.p_out, bus4.g_out}), 32'd0);
      end
      bus4.in_valid_in  = 1'b1;
      bus4.out_ready_in = 1'b1;
      tick();
      bus4.in_valid_in  = 1'b0;
      bus4.out_ready_in = 1'b0;
      check("t5 release out_valid", 32'(bus4.out_valid_out), 32'd0);
      check("t5 release in_ready", 32'(bus4.in_ready_out), 32'd1);
      tick();
      check("t5 idle in_ready", 32'(bus4.in_ready_out), 32'd1);
      check("t5 idle sum kept", 32'(bus4.sum_out), 32'h100F);
      run_op("t5 next", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

      // t6: asynchronous reset two digits into BUSY
      bus4.a_in        = 16'h1234;
      bus4.b_in        = 16'h4321;
      bus4.c_in        = 1'b0;
      bus4.sub_in      = 1'b0;
      bus4.in_valid_in = 1'b1;
      tick();
      bus4.in_valid_in = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 rst in_ready", 32'(bus4.in_ready_out), 32'd1);
      check("t6 rst out_valid", 32'(bus4.out_valid_out), 32'd0);
      check("t6 rst sum", 32'(bus4.sum_out), 32'd0);
      check("t6 rst cvpg", 32'({bus4.c_out, bus4.v_out, bus4.p_out, bus4.g_out}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("t6 after out_valid", 32'(bus4.out_valid_out), 32'd0);
      check("t6 after in_ready", 32'(bus4.in_ready_out), 32'd1);

      // t7: DIGIT=WIDTH instance completes in a single BUSY cycle
      bus16.a_in        = 16'h1234;
      bus16.b_in        = 16'h4321;
      bus16.in_valid_in = 1'b1;
      tick();
      bus16.in_valid_in = 1'b0;
      lat = 0;
      while (!bus16.out_valid_out && lat < 20) begin
         tick();
         lat++;
      end
      check("t7 latency", 32'(lat), 32'd1);
      check("t7 sum", 32'(bus16.sum_out), 32'h5555);
      check("t7 cvpg", 32'({bus16.c_out, bus16.v_out, bus16.p_out, bus16.g_out}), 32'd0);
      bus16.out_ready_in = 1'b1;
      tick();
      bus16.out_ready_in = 1'b0;
      check("t7 back idle", 32'(bus16.in_ready_out), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
